// File: rtl/alu_n8_pkg.sv
// alu_n8_pkg: shared states and constants for the ALU sequential divider
package alu_n8_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = 4;
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = '1;
endpackage

// File: rtl/alu_n8_div_seq_if.sv
// alu_n8_div_seq_if: start/done request bus between ALU control and divider
interface alu_n8_div_seq_if import alu_n8_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
  logic start;
  logic [WIDTH-1:0] dividend, divisor;
  logic busy, done;
  logic [WIDTH-1:0] quotient, remainder;
  logic div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/alu_n8_sub_borrow.sv
// alu_n8_sub_borrow: WIDTH+1-bit subtractor, a minus zero-extended b, split into low diff and borrow bit
module alu_n8_sub_borrow import alu_n8_pkg::*; #(parameter int N = DIV_WIDTH) (
  input  logic [N:0]   a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  assign {borrow, diff} = a - {1'b0, b};
endmodule

// File: rtl/alu_n8_div_seq.sv
// alu_n8_div_seq: restoring unsigned divider, one quotient bit per clock
module alu_n8_div_seq import alu_n8_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic clk,
  input logic reset,
  alu_n8_div_seq_if.slave bus
);
  state_t state, next;
  logic [WIDTH-1:0] pr, sr, dsr, diff;
  logic [WIDTH:0] p;
  logic [CNT_W-1:0] cnt;
  logic dz, borrow, accept;
  // a start coinciding with done is dropped so the requester sees a clean retry
  assign accept = bus.start && state == IDLE && !bus.done;
  assign p = {pr, sr[WIDTH-1]};
  assign bus.busy = state != IDLE;
  alu_n8_sub_borrow #(.N(WIDTH)) u_sub (.a(p), .b(dsr), .diff(diff), .borrow(borrow));
  always_comb begin
    next = accept ? ((bus.divisor == '0) ? FIN : RUN) :
           (state == RUN && cnt == CNT_W'(1)) ? FIN :
           (state == FIN) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_ff @(posedge clk) begin
    if (reset) begin
      pr <= '0;
      sr <= '0;
      dsr <= '0;
      cnt <= '0;
      dz <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= state == FIN;
      if (accept) begin
        sr <= bus.dividend;
        dsr <= bus.divisor;
        pr <= '0;
        cnt <= CNT_W'(WIDTH);
        dz <= bus.divisor == '0;
      end else if (state == RUN) begin
        pr <= borrow ? p[WIDTH-1:0] : diff;
        sr <= {sr[WIDTH-2:0], ~borrow};
        cnt <= cnt - 1'b1;
      end
      if (state == FIN) begin
        bus.quotient <= dz ? DBZ_QUOT : sr;
        bus.remainder <= dz ? sr : pr;
        bus.div_by_zero <= dz;
      end
    end
  end
endmodule

// File: tb/tb_alu_n8_div_seq.sv
// tb_alu_n8_div_seq: directed scoreboard bench for the sequential divider
module tb_alu_n8_div_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic rst_edge = 1'b1;
  logic [7:0] held_q, held_r;
  logic held_dz;
  typedef struct {int q; int r; int dz; int due;} exp_t;
  exp_t exp_q[$];

  alu_n8_div_seq_if #(.WIDTH(8)) bus ();
  alu_n8_div_seq dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_edge <= reset;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", 32'(bus.quotient), e.q);
        chk("remainder", 32'(bus.remainder), e.r);
        chk("div_by_zero", 32'(bus.div_by_zero), e.dz);
        chk("done_latency", cyc, e.due);
      end
    end else if (!rst_edge) begin
      chk("hold_quotient", 32'(bus.quotient), 32'(held_q));
      chk("hold_remainder", 32'(bus.remainder), 32'(held_r));
      chk("hold_dz", 32'(bus.div_by_zero), 32'(held_dz));
    end
    held_q = bus.quotient;
    held_r = bus.remainder;
    held_dz = bus.div_by_zero;
  end

  task automatic issue(input int a, input int b, input bit push, input int q, input int r, input int dz, input int lat);
    @(negedge clk);
    bus.dividend = 8'(a);
    bus.divisor = 8'(b);
    bus.start = 1'b1;
    if (push) exp_q.push_back('{q, r, dz, cyc + 1 + lat});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) return;
    end
    chk("wait_idle_timeout", 1, 0);
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_quotient"}, 32'(bus.quotient), 0);
    chk({tag, "_remainder"}, 32'(bus.remainder), 0);
    chk({tag, "_dz"}, 32'(bus.div_by_zero), 0);
  endtask

  initial begin
    int a, b;
    bit seen;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    issue(200, 7, 1, 28, 4, 0, 9);
    @(negedge clk);
    chk("busy_running", 32'(bus.busy), 1);
    wait_idle();
    issue(255, 1, 1, 255, 0, 0, 9);   wait_idle();
    issue(255, 255, 1, 1, 0, 0, 9);   wait_idle();
    issue(5, 9, 1, 0, 5, 0, 9);       wait_idle();
    issue(0, 3, 1, 0, 0, 0, 9);       wait_idle();

    issue(77, 0, 1, 255, 77, 1, 1);   wait_idle();
    issue(10, 3, 1, 3, 1, 0, 9);      wait_idle();

    issue(100, 10, 1, 10, 0, 0, 9);
    repeat (2) @(negedge clk);
    bus.dividend = 8'd50;
    bus.divisor = 8'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("busy_ignored_start", 32'(bus.busy), 1);
    wait_idle();

    issue(12, 4, 1, 3, 0, 0, 9);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    chk("done_seen", 32'(seen), 1);
    bus.dividend = 8'd40;
    bus.divisor = 8'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_done_start", 32'(bus.busy), 0);
    wait_idle();

    issue(200, 7, 1, 28, 4, 0, 9);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk_zero("midreset");
    reset = 1'b0;
    issue(9, 2, 1, 4, 1, 0, 9);       wait_idle();

    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      issue(a, b, 1, a / b, a % b, 0, 9);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    chk("leftover_expect", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
